// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of the RV32I pipeline. Holds the 32x32
//   architectural register file, decodes the instruction sitting in the
//   fetch-stage IR, and registers operands, immediate and control into the
//   ID/EX pipeline register every cycle. A load in EX whose rd is read by
//   the instruction in ID stalls fetch for one cycle and inserts a bubble.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   inst, pc_in             instruction and its PC from the fetch IR
//   flush                   squash the instruction in ID (redirect from EX)
//   wb_en, wb_rd, wb_data   register write-back port
//   PC_Write, IR_Write      fetch update enables (0 = stall)
//   ex_*                    ID/EX pipeline register contents
// ---------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        PC_Write,
  output logic        IR_Write,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  aluOp;
    logic        aluSrcImm;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
  } idex_t;

  logic [31:0] rf_q [32];
  idex_t       idex_q;
  idex_t       idex_d;
  idex_t       dec;
  logic        rs1Used;
  logic        rs2Used;
  logic        stall;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immB;
  logic [31:0] immU;
  logic [31:0] immJ;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign immI   = {{20{inst[31]}}, inst[31:20]};
  assign immS   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign immB   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign immU   = {inst[31:12], 12'b0};
  assign immJ   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Register file. Entry 0 is never written so x0 always reads back zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Decode. Index fields that the format does not use are forced to zero
  // (and so is their operand data), and rd is zero unless the instruction
  // writes a register, so downstream comparisons never match stray bits.
  always_comb begin
    dec     = '0;
    rs1Used = 1'b0;
    rs2Used = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.valid    = 1'b1;
        dec.regWrite = 1'b1;
        dec.funct3   = funct3;
        dec.aluOp    = {inst[30], funct3};
        rs1Used      = 1'b1;
        rs2Used      = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.valid     = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        dec.imm       = immI;
        dec.funct3    = funct3;
        // Only the right shifts use inst[30] to pick arithmetic vs logical.
        dec.aluOp     = {(funct3 == 3'b101) ? inst[30] : 1'b0, funct3};
        rs1Used       = 1'b1;
      end
      OPC_LOAD: begin
        dec.valid     = 1'b1;
        dec.memRead   = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        dec.imm       = immI;
        dec.funct3    = funct3;
        rs1Used       = 1'b1;
      end
      OPC_STORE: begin
        dec.valid     = 1'b1;
        dec.memWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        dec.imm       = immS;
        dec.funct3    = funct3;
        rs1Used       = 1'b1;
        rs2Used       = 1'b1;
      end
      OPC_BRANCH: begin
        dec.valid  = 1'b1;
        dec.imm    = immB;
        dec.funct3 = funct3;
        dec.aluOp  = 4'b1000;
        rs1Used    = 1'b1;
        rs2Used    = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.valid     = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        dec.imm       = immU;
      end
      OPC_JAL: begin
        dec.valid    = 1'b1;
        dec.regWrite = 1'b1;
        dec.imm      = immJ;
      end
      OPC_JALR: begin
        dec.valid     = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        dec.imm       = immI;
        dec.funct3    = funct3;
        rs1Used       = 1'b1;
      end
      default: ;
    endcase

    dec.pc = pc_in;
    if (rs1Used)      dec.rs1 = inst[19:15];
    if (rs2Used)      dec.rs2 = inst[24:20];
    if (dec.regWrite) dec.rd  = inst[11:7];

    // Write-through bypass lets a same-edge write-back reach ID/EX directly.
    if (dec.rs1 != 5'd0)
      dec.rs1Data = (wb_en && (wb_rd == dec.rs1)) ? wb_data : rf_q[dec.rs1];
    if (dec.rs2 != 5'd0)
      dec.rs2Data = (wb_en && (wb_rd == dec.rs2)) ? wb_data : rf_q[dec.rs2];
  end

  // Load-use detection and ID/EX next state. The bubble inserted by a stall
  // clears the condition, so each hazard costs exactly one cycle. A flush
  // overrides the stall and lets fetch proceed to the redirect target.
  always_comb begin
    stall = idex_q.valid && idex_q.memRead && (idex_q.rd != 5'd0) &&
            ((rs1Used && (idex_q.rd == dec.rs1)) ||
             (rs2Used && (idex_q.rd == dec.rs2)));
    PC_Write = flush || !stall;
    IR_Write = flush || !stall;
    idex_d   = (dec.valid && !flush && !stall) ? dec : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid       = idex_q.valid;
  assign ex_pc          = idex_q.pc;
  assign ex_rs1_data    = idex_q.rs1Data;
  assign ex_rs2_data    = idex_q.rs2Data;
  assign ex_imm         = idex_q.imm;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_rd          = idex_q.rd;
  assign ex_funct3      = idex_q.funct3;
  assign ex_alu_op      = idex_q.aluOp;
  assign ex_alu_src_imm = idex_q.aluSrcImm;
  assign ex_mem_read    = idex_q.memRead;
  assign ex_mem_write   = idex_q.memWrite;
  assign ex_reg_write   = idex_q.regWrite;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Testbench for id_stage. Instructions are built from an "intent" (kind,
//   register numbers, immediate value); the expected ID/EX contents come
//   from that intent plus a register-file array, never from decoding bits.
// ---------------------------------------------------------------------------
module tb_id_stage;

  typedef enum int {K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_LUI,
                    K_AUIPC, K_JAL, K_JALR, K_ILLEGAL} kind_e;

  typedef struct packed {
    logic        valid;
    logic        useRs1;
    logic        useRs2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  aluOp;
    logic [31:0] imm;
    logic        srcImm;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
  } intent_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  aluOp;
    logic        srcImm;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        PC_Write;
  logic        IR_Write;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;

  int          checks;
  int          failures;
  logic [31:0] mRf [32];
  exp_t        mEx;
  intent_t     curInt;
  logic [31:0] curInst;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .PC_Write(PC_Write), .IR_Write(IR_Write), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts, asserts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Assemble an instruction from its intent and record what decode should yield.
  task automatic buildInst(input kind_e kind, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic b30,
                           input logic [31:0] imm);
    logic [31:0] u;
    u = imm;
    curInt = '0;
    curInt.valid = 1'b1;
    curInt.rs1 = rs1;
    curInt.rs2 = rs2;
    curInt.rd = rd;
    case (kind)
      K_OP: begin
        curInst = {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
        curInt.regWrite = 1'b1; curInt.useRs1 = 1'b1; curInt.useRs2 = 1'b1;
        curInt.f3 = f3; curInt.aluOp = {b30, f3};
      end
      K_OPIMM: begin
        if (f3 == 3'd5) u = (b30 ? 32'd1024 : 32'd0) + (imm & 32'd31);
        else if (f3 == 3'd1) u = imm & 32'd31;
        curInst = {u[11:0], rs1, f3, rd, 7'b0010011};
        curInt.regWrite = 1'b1; curInt.srcImm = 1'b1; curInt.useRs1 = 1'b1;
        curInt.f3 = f3; curInt.imm = u;
        curInt.aluOp = {(f3 == 3'd5) && b30, f3};
      end
      K_LOAD: begin
        curInst = {u[11:0], rs1, f3, rd, 7'b0000011};
        curInt.memRead = 1'b1; curInt.regWrite = 1'b1; curInt.srcImm = 1'b1;
        curInt.useRs1 = 1'b1; curInt.f3 = f3; curInt.imm = u;
      end
      K_STORE: begin
        curInst = {u[11:5], rs2, rs1, f3, u[4:0], 7'b0100011};
        curInt.memWrite = 1'b1; curInt.srcImm = 1'b1;
        curInt.useRs1 = 1'b1; curInt.useRs2 = 1'b1; curInt.f3 = f3; curInt.imm = u;
      end
      K_BRANCH: begin
        curInst = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], 7'b1100011};
        curInt.useRs1 = 1'b1; curInt.useRs2 = 1'b1; curInt.f3 = f3;
        curInt.imm = u; curInt.aluOp = 4'd8;
      end
      K_LUI, K_AUIPC: begin
        curInst = {u[31:12], rd, (kind == K_LUI) ? 7'b0110111 : 7'b0010111};
        curInt.regWrite = 1'b1; curInt.srcImm = 1'b1; curInt.imm = u;
      end
      K_JAL: begin
        curInst = {u[20], u[10:1], u[11], u[19:12], rd, 7'b1101111};
        curInt.regWrite = 1'b1; curInt.imm = u;
      end
      K_JALR: begin
        curInst = {u[11:0], rs1, 3'b000, rd, 7'b1100111};
        curInt.regWrite = 1'b1; curInt.srcImm = 1'b1; curInt.useRs1 = 1'b1;
        curInt.imm = u;
      end
      default: begin
        curInst = {u[24:0], f3[0] ? 7'b1110011 : 7'b1111111};
        curInt = '0;
      end
    endcase
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && (wb_rd == r)) return wb_data;
    return mRf[r];
  endfunction

  function automatic logic modelStall();
    return mEx.valid && mEx.memRead && (mEx.rd != 5'd0) &&
           ((curInt.useRs1 && (mEx.rd == curInt.rs1)) ||
            (curInt.useRs2 && (mEx.rd == curInt.rs2)));
  endfunction

  task automatic checkEx();
    checkOutput("ex_valid",   32'(ex_valid),       32'(mEx.valid));
    checkOutput("ex_pc",      ex_pc,               mEx.pc);
    checkOutput("ex_rs1_data", ex_rs1_data,        mEx.rs1Data);
    checkOutput("ex_rs2_data", ex_rs2_data,        mEx.rs2Data);
    checkOutput("ex_imm",     ex_imm,              mEx.imm);
    checkOutput("ex_rs1",     32'(ex_rs1),         32'(mEx.rs1));
    checkOutput("ex_rs2",     32'(ex_rs2),         32'(mEx.rs2));
    checkOutput("ex_rd",      32'(ex_rd),          32'(mEx.rd));
    checkOutput("ex_funct3",  32'(ex_funct3),      32'(mEx.f3));
    checkOutput("ex_alu_op",  32'(ex_alu_op),      32'(mEx.aluOp));
    checkOutput("ex_alu_src_imm", 32'(ex_alu_src_imm), 32'(mEx.srcImm));
    checkOutput("ex_mem_read",  32'(ex_mem_read),  32'(mEx.memRead));
    checkOutput("ex_mem_write", 32'(ex_mem_write), 32'(mEx.memWrite));
    checkOutput("ex_reg_write", 32'(ex_reg_write), 32'(mEx.regWrite));
  endtask

  // Drive one cycle's inputs and check the fetch enables before the edge.
  task automatic driveInputs(input logic [31:0] pcv, input logic fl, input logic we,
                             input logic [4:0] wr, input logic [31:0] wd);
    logic expStall;
    inst = curInst; pc_in = pcv; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #2;
    expStall = modelStall();
    checkOutput("PC_Write", 32'(PC_Write), 32'(!(expStall && !fl)));
    checkOutput("IR_Write", 32'(IR_Write), 32'(!(expStall && !fl)));
  endtask

  // Advance the model across the rising edge and compare ID/EX after it.
  task automatic clockAndCheck();
    exp_t n;
    n = '0;
    if (curInt.valid && !flush && !modelStall()) begin
      n.valid    = 1'b1;
      n.pc       = pc_in;
      n.rs1      = curInt.useRs1 ? curInt.rs1 : 5'd0;
      n.rs2      = curInt.useRs2 ? curInt.rs2 : 5'd0;
      n.rd       = curInt.regWrite ? curInt.rd : 5'd0;
      n.rs1Data  = modelRead(n.rs1);
      n.rs2Data  = modelRead(n.rs2);
      n.imm      = curInt.imm;
      n.f3       = curInt.f3;
      n.aluOp    = curInt.aluOp;
      n.srcImm   = curInt.srcImm;
      n.memRead  = curInt.memRead;
      n.memWrite = curInt.memWrite;
      n.regWrite = curInt.regWrite;
    end
    if (wb_en && (wb_rd != 5'd0)) mRf[wb_rd] = wb_data;
    mEx = n;
    @(posedge clk);
    #1;
    checkEx();
  endtask

  task automatic applyStimulus(input logic [31:0] pcv, input logic fl, input logic we,
                               input logic [4:0] wr, input logic [31:0] wd);
    driveInputs(pcv, fl, we, wr, wd);
    clockAndCheck();
  endtask

  task automatic randomInst();
    kind_e       kind;
    int          k;
    int          r;
    logic [31:0] t;
    logic [31:0] imm;
    k = int'($urandom_range(0, 12));
    case (k)
      0: kind = K_OP;      1: kind = K_OPIMM;  2: kind = K_STORE;
      3: kind = K_BRANCH;  4: kind = K_LUI;    5: kind = K_AUIPC;
      6: kind = K_JAL;     7: kind = K_JALR;   8: kind = K_ILLEGAL;
      9: kind = K_OP;      default: kind = K_LOAD;
    endcase
    t = $urandom;
    case (kind)
      K_BRANCH: begin r = int'($urandom_range(0, 4095)) - 2048; imm = 32'(r * 2); end
      K_JAL:    begin r = int'($urandom_range(0, 1048575)) - 524288; imm = 32'(r * 2); end
      K_LUI, K_AUIPC: imm = {t[31:12], 12'b0};
      K_ILLEGAL: imm = t;
      default:  begin r = int'($urandom_range(0, 4095)) - 2048; imm = 32'(r); end
    endcase
    buildInst(kind, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), imm);
  endtask

  initial begin
    logic hold;
    logic [31:0] pcv;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    inst = '0; pc_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    mEx = '0;
    for (int i = 0; i < 32; i++) mRf[i] = '0;
    curInt = '0;
    curInst = '0;

    // Reset state: bubble in ID/EX, fetch enabled.
    #3;
    checkEx();
    checkOutput("reset_PC_Write", 32'(PC_Write), 32'd1);
    checkOutput("reset_IR_Write", 32'(IR_Write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write x5 while an illegal opcode sits in ID.
    buildInst(K_ILLEGAL, 0, 0, 0, 0, 0, 32'd0);
    applyStimulus(32'h100, 0, 1, 5'd5, 32'h1234_5678);
    checkOutput("illegal_bubble", 32'(ex_valid), 32'd0);

    // add x6,x5,x0 reads the written value.
    buildInst(K_OP, 6, 5, 0, 3'd0, 0, 32'd0);
    applyStimulus(32'h104, 0, 0, 5'd0, 32'd0);
    checkOutput("add_rs1_data", ex_rs1_data, 32'h1234_5678);
    checkOutput("add_alu_op", 32'(ex_alu_op), 32'd0);

    // addi x4,x3,-1 with a same-edge write of x3.
    buildInst(K_OPIMM, 4, 3, 0, 3'd0, 0, 32'hFFFF_FFFF);
    applyStimulus(32'h108, 0, 1, 5'd3, 32'hA5A5_A5A5);
    checkOutput("bypass_rs1_data", ex_rs1_data, 32'hA5A5_A5A5);
    checkOutput("addi_imm", ex_imm, 32'hFFFF_FFFF);

    // Write to x0 (both same-edge and afterwards) leaves x0 reading zero.
    buildInst(K_OP, 1, 0, 3, 3'd0, 0, 32'd0);
    applyStimulus(32'h10C, 0, 1, 5'd0, 32'hFFFF_FFFF);
    checkOutput("x0_same_edge", ex_rs1_data, 32'd0);
    buildInst(K_OP, 1, 0, 0, 3'd0, 1, 32'd0);
    applyStimulus(32'h110, 0, 0, 5'd0, 32'd0);
    checkOutput("x0_after", ex_rs1_data, 32'd0);

    // Immediate formats.
    buildInst(K_STORE, 0, 1, 2, 3'd2, 0, 32'hFFFF_FFF8);
    applyStimulus(32'h114, 0, 0, 5'd0, 32'd0);
    checkOutput("sw_imm", ex_imm, 32'hFFFF_FFF8);
    checkOutput("sw_mem_write", 32'(ex_mem_write), 32'd1);
    buildInst(K_LUI, 1, 0, 0, 3'd0, 0, 32'hABCD_E000);
    applyStimulus(32'h118, 0, 0, 5'd0, 32'd0);
    checkOutput("lui_imm", ex_imm, 32'hABCD_E000);
    buildInst(K_BRANCH, 0, 1, 2, 3'd0, 0, 32'hFFFF_FFFC);
    applyStimulus(32'h11C, 0, 0, 5'd0, 32'd0);
    checkOutput("beq_imm", ex_imm, 32'hFFFF_FFFC);
    checkOutput("beq_alu_op", 32'(ex_alu_op), 32'd8);

    // lw x7,0(x1); add x8,x7,x2 -> one stall cycle, then the add issues.
    buildInst(K_LOAD, 7, 1, 0, 3'd2, 0, 32'd0);
    applyStimulus(32'h120, 0, 0, 5'd0, 32'd0);
    buildInst(K_OP, 8, 7, 2, 3'd0, 0, 32'd0);
    driveInputs(32'h124, 0, 0, 5'd0, 32'd0);
    checkOutput("loaduse_PC_Write", 32'(PC_Write), 32'd0);
    clockAndCheck();
    checkOutput("loaduse_bubble", 32'(ex_valid), 32'd0);
    applyStimulus(32'h124, 0, 0, 5'd0, 32'd0);
    checkOutput("loaduse_issue", 32'(ex_valid), 32'd1);

    // lw x7 then lui x7: no source register, no stall.
    buildInst(K_LOAD, 7, 1, 0, 3'd2, 0, 32'd0);
    applyStimulus(32'h128, 0, 0, 5'd0, 32'd0);
    buildInst(K_LUI, 7, 0, 0, 3'd0, 0, 32'h0000_1000);
    applyStimulus(32'h12C, 0, 0, 5'd0, 32'd0);
    checkOutput("lui_no_stall", 32'(ex_valid), 32'd1);

    // Flush beats a load-use hazard.
    buildInst(K_LOAD, 7, 1, 0, 3'd2, 0, 32'd0);
    applyStimulus(32'h130, 0, 0, 5'd0, 32'd0);
    buildInst(K_OP, 8, 7, 2, 3'd0, 0, 32'd0);
    driveInputs(32'h134, 1, 0, 5'd0, 32'd0);
    checkOutput("flush_PC_Write", 32'(PC_Write), 32'd1);
    clockAndCheck();
    checkOutput("flush_bubble", 32'(ex_valid), 32'd0);

    // Asynchronous reset between edges during a stall.
    buildInst(K_LOAD, 9, 1, 0, 3'd2, 0, 32'd4);
    applyStimulus(32'h140, 0, 0, 5'd0, 32'd0);
    buildInst(K_OP, 10, 9, 2, 3'd0, 0, 32'd0);
    driveInputs(32'h144, 0, 0, 5'd0, 32'd0);
    checkOutput("pre_reset_stall", 32'(PC_Write), 32'd0);
    rst_n = 1'b0;
    #1;
    mEx = '0;
    for (int i = 0; i < 32; i++) mRf[i] = '0;
    checkEx();
    checkOutput("async_PC_Write", 32'(PC_Write), 32'd1);
    checkOutput("async_IR_Write", 32'(IR_Write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    clockAndCheck();
    checkOutput("post_reset_rs1_data", ex_rs1_data, 32'd0);

    // Randomized traffic; a stalled instruction is held as the fetch IR would.
    hold = 1'b0;
    pcv = 32'h200;
    for (int n = 0; n < 400; n++) begin
      logic fl;
      if (!hold) begin
        randomInst();
        pcv = $urandom & 32'hFFFF_FFFC;
      end
      fl = ($urandom_range(0, 7) == 0);
      driveInputs(pcv, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      hold = modelStall() && !fl;
      clockAndCheck();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline, directly downstream of the fetch stage's instruction register. It holds the architectural register file and decodes the fetched instruction into operands, immediate and control. It registers the result into the ID/EX pipeline register each cycle. It detects load-use hazards and drives the fetch stage's `PC_Write`/`IR_Write` enables to stall it.

## Interface
Parameters: none (XLEN fixed at 32, 32 architectural registers).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inst` input 32: instruction from the fetch-stage IR.
- `pc_in` input 32: PC associated with `inst`.
- `flush` input 1: squash the instruction currently in ID (taken branch/jump from EX).
- `wb_en` input 1: register write-back enable.
- `wb_rd` input 5: write-back destination.
- `wb_data` input 32: write-back data.
- `PC_Write` output 1: fetch PC update enable; 0 = stall.
- `IR_Write` output 1: fetch IR update enable; 0 = stall.
- `ex_valid` output 1: ID/EX holds a real instruction; 0 = bubble.
- `ex_pc` output 32: PC of the instruction in ID/EX.
- `ex_rs1_data` output 32: rs1 operand.
- `ex_rs2_data` output 32: rs2 operand.
- `ex_imm` output 32: sign-extended immediate.
- `ex_rs1` output 5: rs1 index.
- `ex_rs2` output 5: rs2 index.
- `ex_rd` output 5: rd index.
- `ex_funct3` output 3: funct3 field.
- `ex_alu_op` output 4: ALU operation.
- `ex_alu_src_imm` output 1: ALU B operand = imm.
- `ex_mem_read` output 1: load.
- `ex_mem_write` output 1: store.
- `ex_reg_write` output 1: writes rd.

## Operation
- **Register file:** 32×32; x0 reads 0 and is never written. Write occurs on the rising edge when `wb_en && wb_rd != 0`. Reads are combinational with write-through bypass: if `wb_en && wb_rd == rsN && rsN != 0`, the read returns `wb_data`.
- **Decode by opcode `inst[6:0]`:**
  - OP 0110011: reg_write, rs1+rs2 used, `alu_op = {inst[30], funct3}`.
  - OP-IMM 0010011: reg_write, alu_src_imm, I-imm, rs1 used. `alu_op = {funct3==3'b101 ? inst[30] : 0, funct3}`.
  - LOAD 0000011: mem_read, reg_write, alu_src_imm, I-imm, `alu_op = 0000`, rs1 used.
  - STORE 0100011: mem_write, alu_src_imm, S-imm, `alu_op = 0000`, rs1+rs2 used.
  - BRANCH 1100011: B-imm, `alu_op = 1000`, rs1+rs2 used.
  - LUI 0110111 / AUIPC 0010111: reg_write, alu_src_imm, U-imm (`inst[31:12]<<12`), `alu_op = 0000`.
  - JAL 1101111: reg_write, J-imm. JALR 1100111: reg_write, alu_src_imm, I-imm, rs1 used. Both use `alu_op = 0000`.
  - Any other opcode: decoded as a bubble.
- **Immediates:** all sign-extended from `inst[31]`. B- and J-immediates have bit 0 = 0.
- **Load-use hazard (combinational):** `stall = ex_valid && ex_mem_read && ex_rd != 0 && ((rs1 used && ex_rd == rs1) || (rs2 used && ex_rd == rs2))`.
- **Stall:** `PC_Write = IR_Write = ~stall`. ID/EX loads a bubble; the instruction stays in the fetch IR and is re-decoded next cycle.
- **Bubble:** `ex_valid = 0`, all control outputs 0, all data/index fields 0.
- **Priority:** `flush` > `stall` > normal.
  - Flush: ID/EX loads a bubble; `PC_Write = IR_Write = 1` regardless of hazard.
  - Normal: ID/EX loads the decoded instruction with `ex_valid = 1`.

## Timing
- **Reset:** while `rst_n` = 0, all `ex_*` outputs = 0 and all registers x1–x31 = 0. `PC_Write = IR_Write = 1`, since ID/EX holds a bubble.
- **Reset release:** decode resumes on the first rising edge after `rst_n` rises.
- **Latency:** 1 cycle, `inst` → `ex_*`.
- **Stall length:** exactly 1 cycle per load-use hazard, because the inserted bubble clears the hazard condition.
- **Same-edge write-back:** when write-back and decode target the same register on the same edge, ID/EX captures `wb_data` via the bypass.
- **Mid-operation reset:** asserting `rst_n` low mid-stall drops the stall immediately, clears the pipeline register, and does not corrupt fetch enables beyond that cycle.

## Test plan
- **Register write/read:** reset, then write x5 = 0x1234_5678 via the WB port. Decode `add x6,x5,x0` → next cycle `ex_rs1_data = 0x12345678`, `ex_alu_op = 0000`, `ex_reg_write = 1`, `ex_valid = 1`.
- **Bypass and x0:** same edge `wb_en = 1`, `wb_rd = 3`, `wb_data = 0xA5A5A5A5`, `inst = addi x4,x3,-1` → `ex_rs1_data = 0xA5A5A5A5`, `ex_imm = 0xFFFFFFFF`. A write to x0 leaves x0 reading 0.
- **Immediates:** decode `sw x2,-8(x1)` → `ex_imm = 0xFFFFFFF8`, `ex_mem_write = 1`. `lui x1,0xABCDE` → `ex_imm = 0xABCDE000`. `beq` with offset −4 → `ex_imm = 0xFFFFFFFC`, `ex_alu_op = 1000`.
- **Load-use:** `lw x7,0(x1)` followed by `add x8,x7,x2` → one cycle with `PC_Write = IR_Write = 0` and `ex_valid = 0`, then the add issues with `ex_valid = 1`. `lw x7` followed by `lui x7` → no stall.
- **Flush priority:** load-use condition and `flush = 1` together → `PC_Write = 1` and a bubble in ID/EX. Illegal opcode 0x0000007F → bubble.
- **Async reset:** pull `rst_n` low between clock edges during a stall → all `ex_*` = 0 immediately and `PC_Write = 1`.
